// File: rtl/bram_arbiter.sv
// Arbitrates the single-ported data BRAM between the CPU MEM stage and a debug dump streamer.
// Optional ARB_STALL_CNT_EN adds o_stall_cnt, a saturating count of denied CPU request cycles.
module bram_arbiter #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_gnt,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_rvalid,
  input  logic              i_dbg_start,
  input  logic [ADDR_W-1:0] i_dbg_base,
  input  logic [ADDR_W:0]   i_dbg_len,
  output logic [DATA_W-1:0] o_dbg_data,
  output logic              o_dbg_valid,
  input  logic              i_dbg_ready,
  output logic              o_dbg_busy,
  output logic              o_dbg_done,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
`ifdef ARB_STALL_CNT_EN
  output logic [15:0]       o_stall_cnt,
`endif
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int unsigned LEN_W    = ADDR_W + 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    remain_q, remain_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                dbg_valid_q, dbg_valid_d;
  logic [DATA_W-1:0]   dbg_data_q, dbg_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cpu_rvalid_q, cpu_rvalid_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;

  logic word_taken_c;
  logic buf_free_c;
  logic dump_want_c;
  logic starved_c;
  logic cpu_gnt_c;
  logic dump_take_c;

  // Slot arbitration: CPU first unless the dump engine has been starved long enough
  always_comb begin
    word_taken_c = dbg_valid_q && i_dbg_ready;
    buf_free_c   = !dbg_valid_q || i_dbg_ready;
    dump_want_c  = (state_q == ST_RUN) && (remain_q != '0) && buf_free_c;
    starved_c    = (starve_q == STARVE_W'(STARVE_LIMIT));
    cpu_gnt_c    = i_cpu_req && !(starved_c && dump_want_c);
    dump_take_c  = dump_want_c && !cpu_gnt_c;
  end

  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (cpu_gnt_c) begin
      o_mem_we    = i_cpu_we;
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
    end else if (dump_take_c) begin
      o_mem_addr  = addr_q;
    end
  end

  // i_mem_rdata is launched on the falling edge of the grant cycle, so it is captured at the closing edge
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remain_d     = remain_q;
    starve_d     = starve_q;
    dbg_valid_d  = dbg_valid_q;
    dbg_data_d   = dbg_data_q;
    cpu_rvalid_d = cpu_gnt_c && !i_cpu_we;
    cpu_rdata_d  = cpu_rdata_q;

    if (cpu_gnt_c && !i_cpu_we) begin
      cpu_rdata_d = i_mem_rdata;
    end

    if (cpu_gnt_c && dump_want_c) begin
      starve_d = starve_q + STARVE_W'(1);
    end else if (dump_take_c) begin
      starve_d = '0;
    end

    if (dump_take_c) begin
      dbg_valid_d = 1'b1;
      dbg_data_d  = i_mem_rdata;
      addr_d      = addr_q + ADDR_W'(1);
      remain_d    = remain_q - LEN_W'(1);
    end else if (word_taken_c) begin
      dbg_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_dbg_start) begin
          addr_d   = i_dbg_base;
          remain_d = i_dbg_len;
          state_d  = (i_dbg_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if ((remain_q == '0) && (word_taken_c || !dbg_valid_q)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      remain_q     <= '0;
      starve_q     <= '0;
      dbg_valid_q  <= 1'b0;
      dbg_data_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      starve_q     <= starve_d;
      dbg_valid_q  <= dbg_valid_d;
      dbg_data_q   <= dbg_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  assign o_cpu_gnt    = cpu_gnt_c;
  assign o_cpu_rdata  = cpu_rdata_q;
  assign o_cpu_rvalid = cpu_rvalid_q;
  assign o_dbg_data   = dbg_data_q;
  assign o_dbg_valid  = dbg_valid_q;
  assign o_dbg_busy   = busy_q;
  assign o_dbg_done   = done_q;

`ifdef ARB_STALL_CNT_EN
  localparam int unsigned STALL_W = 16;

  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles the CPU asked but was held off
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (i_cpu_req && !cpu_gnt_c && (stall_cnt_q != {STALL_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: BRAM model, queue-based reference model checked every cycle, directed and random stimulus.
module tb_bram_arbiter;

  localparam int unsigned ADDR_W       = 8;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned DEPTH        = 256;

  logic              clk = 1'b0;
  logic              i_reset;
  logic              i_cpu_req;
  logic              i_cpu_we;
  logic [ADDR_W-1:0] i_cpu_addr;
  logic [DATA_W-1:0] i_cpu_wdata;
  logic              o_cpu_gnt;
  logic [DATA_W-1:0] o_cpu_rdata;
  logic              o_cpu_rvalid;
  logic              i_dbg_start;
  logic [ADDR_W-1:0] i_dbg_base;
  logic [ADDR_W:0]   i_dbg_len;
  logic [DATA_W-1:0] o_dbg_data;
  logic              o_dbg_valid;
  logic              i_dbg_ready;
  logic              o_dbg_busy;
  logic              o_dbg_done;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;
`ifdef ARB_STALL_CNT_EN
  logic [15:0]       o_stall_cnt;
`endif

  always #5 clk = ~clk;

  bram_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .i_reset(i_reset),
    .i_cpu_req(i_cpu_req),
    .i_cpu_we(i_cpu_we),
    .i_cpu_addr(i_cpu_addr),
    .i_cpu_wdata(i_cpu_wdata),
    .o_cpu_gnt(o_cpu_gnt),
    .o_cpu_rdata(o_cpu_rdata),
    .o_cpu_rvalid(o_cpu_rvalid),
    .i_dbg_start(i_dbg_start),
    .i_dbg_base(i_dbg_base),
    .i_dbg_len(i_dbg_len),
    .o_dbg_data(o_dbg_data),
    .o_dbg_valid(o_dbg_valid),
    .i_dbg_ready(i_dbg_ready),
    .o_dbg_busy(o_dbg_busy),
    .o_dbg_done(o_dbg_done),
    .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
`ifdef ARB_STALL_CNT_EN
    .o_stall_cnt(o_stall_cnt),
`endif
    .i_mem_rdata(i_mem_rdata)
  );

  // BRAM: write on rising edge, registered read data on falling edge
  logic [DATA_W-1:0] bram [DEPTH];
  always @(posedge clk) if (o_mem_we === 1'b1) bram[o_mem_addr] <= o_mem_wdata;
  always @(negedge clk) i_mem_rdata <= bram[o_mem_addr];

  function automatic logic [DATA_W-1:0] init_word(input int a);
    return 32'hA500_0000 + 32'(a) * 32'h0001_0101;
  endfunction

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: words still to fetch kept as an address queue, plus output/pulse flags
  logic [DATA_W-1:0] m_mem [DEPTH];
  int unsigned       m_pend [$];
  bit                m_active, m_done, m_valid, m_rvalid;
  logic [DATA_W-1:0] m_data, m_rdata;
  int unsigned       m_starve;
  bit                chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      bit want, cpu_win, dump_win, exp_we, fin, done_n, rvalid_n;
      logic [ADDR_W-1:0] exp_addr;

      check("cyc_rvalid", o_cpu_rvalid, m_rvalid);
      if (m_rvalid) check("cyc_rdata", o_cpu_rdata, m_rdata);
      check("cyc_dbg_valid", o_dbg_valid, m_valid);
      if (m_valid) check("cyc_dbg_data", o_dbg_data, m_data);
      check("cyc_busy", o_dbg_busy, m_active);
      check("cyc_done", o_dbg_done, m_done);

      want     = m_active && (m_pend.size() > 0) && (!m_valid || i_dbg_ready);
      cpu_win  = i_cpu_req && !(want && (m_starve >= STARVE_LIMIT));
      dump_win = want && !cpu_win;
      exp_we   = cpu_win && i_cpu_we;
      exp_addr = '0;
      if (cpu_win) exp_addr = i_cpu_addr;
      else if (dump_win) exp_addr = ADDR_W'(m_pend[0]);

      check("cyc_gnt", o_cpu_gnt, cpu_win);
      check("cyc_mem_we", o_mem_we, exp_we);
      check("cyc_mem_addr", o_mem_addr, exp_addr);
      if (exp_we) check("cyc_mem_wdata", o_mem_wdata, i_cpu_wdata);
      else if (!cpu_win) check("cyc_mem_wdata_idle", o_mem_wdata, 0);

      rvalid_n = cpu_win && !i_cpu_we;
      if (rvalid_n) m_rdata = m_mem[i_cpu_addr];
      if (exp_we) m_mem[i_cpu_addr] = i_cpu_wdata;

      if (cpu_win && want) m_starve++;
      else if (dump_win) m_starve = 0;

      fin = m_active && (m_pend.size() == 0) && (!m_valid || i_dbg_ready);
      if (dump_win) begin
        m_data  = m_mem[m_pend.pop_front()];
        m_valid = 1'b1;
      end else if (m_valid && i_dbg_ready) begin
        m_valid = 1'b0;
      end

      done_n = 1'b0;
      if (fin) begin
        m_active = 1'b0;
        done_n   = 1'b1;
      end else if (!m_active && !m_done && i_dbg_start) begin
        if (i_dbg_len == 0) done_n = 1'b1;
        else begin
          m_active = 1'b1;
          for (int i = 0; i < int'(i_dbg_len); i++) m_pend.push_back(32'((int'(i_dbg_base) + i) % 256));
        end
      end
      m_done   = done_n;
      m_rvalid = rvalid_n;

      if (i_reset) begin
        m_active = 1'b0;
        m_done   = 1'b0;
        m_valid  = 1'b0;
        m_rvalid = 1'b0;
        m_starve = 0;
        m_pend.delete();
      end
    end
  end

  logic [DATA_W-1:0] got [$];
  int                got_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_cpu_req   = 1'b0;
    i_cpu_we    = 1'b0;
    i_cpu_addr  = '0;
    i_cpu_wdata = '0;
    i_dbg_start = 1'b0;
    i_dbg_base  = '0;
    i_dbg_len   = '0;
    i_dbg_ready = 1'b1;
  endtask

  task automatic start_dump(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len);
    tick();
    i_dbg_start = 1'b1;
    i_dbg_base  = base;
    i_dbg_len   = len;
    #2;
  endtask

  // Runs until a few cycles past the done pulse, collecting accepted words
  task automatic drain(input int max_cyc);
    int post;
    post = -1;
    for (int c = 0; c < max_cyc && post != 0; c++) begin
      tick();
      i_dbg_start = 1'b0;
      #2;
      if (o_dbg_valid && i_dbg_ready) got.push_back(o_dbg_data);
      if (o_dbg_done) begin
        got_done++;
        post = 3;
      end else if (post > 0) begin
        post--;
      end
    end
  endtask

  initial begin
    int denials [$];
    int n_acc;
    int n_done;
    bit seen;
    bit gnt_seen;
    logic [DATA_W-1:0] hold;

    for (int i = 0; i < int'(DEPTH); i++) begin
      bram[i]  = init_word(i);
      m_mem[i] = init_word(i);
    end
    m_active = 1'b0; m_done = 1'b0; m_valid = 1'b0; m_rvalid = 1'b0;
    m_data = '0; m_rdata = '0; m_starve = 0;
    idle_inputs();
    i_reset = 1'b1;

    tick();
    chk_en = 1'b1;
    #2;
    check("rst_rvalid", o_cpu_rvalid, 0);
    check("rst_rdata", o_cpu_rdata, 0);
    check("rst_dbg_valid", o_dbg_valid, 0);
    check("rst_dbg_data", o_dbg_data, 0);
    check("rst_busy", o_dbg_busy, 0);
    check("rst_done", o_dbg_done, 0);
    check("rst_mem_we", o_mem_we, 0);
    check("rst_mem_addr", o_mem_addr, 0);
    check("rst_mem_wdata", o_mem_wdata, 0);

    // CPU write then read of the same word
    tick();
    i_reset = 1'b0;
    i_cpu_req = 1'b1; i_cpu_we = 1'b1; i_cpu_addr = 8'h10; i_cpu_wdata = 32'hDEADBEEF;
    #2;
    check("t1_wr_gnt", o_cpu_gnt, 1);
    tick();
    i_cpu_we = 1'b0;
    #2;
    check("t1_rd_gnt", o_cpu_gnt, 1);
    check("t1_no_rvalid_for_wr", o_cpu_rvalid, 0);
    tick();
    i_cpu_req = 1'b0;
    #2;
    check("t1_rvalid", o_cpu_rvalid, 1);
    check("t1_rdata", o_cpu_rdata, 32'hDEADBEEF);
    tick();
    #2;
    check("t1_rvalid_one_cycle", o_cpu_rvalid, 0);

    // Plain dump of three words
    got.delete(); got_done = 0;
    start_dump(8'h00, 9'd3);
    drain(40);
    check("t2_count", got.size(), 3);
    for (int i = 0; i < 3; i++) check("t2_word", (got.size() > i) ? got[i] : 32'h0, init_word(i));
    check("t2_done_once", got_done, 1);
    check("t2_busy_after", o_dbg_busy, 0);

    // Address wraps past the top of memory
    got.delete(); got_done = 0;
    start_dump(8'hFE, 9'd4);
    drain(40);
    check("t3_count", got.size(), 4);
    check("t3_w0", (got.size() > 0) ? got[0] : 32'h0, 32'hA5FE_FEFE);
    check("t3_w1", (got.size() > 1) ? got[1] : 32'h0, 32'hA5FF_FFFF);
    check("t3_w2", (got.size() > 2) ? got[2] : 32'h0, 32'hA500_0000);
    check("t3_w3", (got.size() > 3) ? got[3] : 32'h0, 32'hA501_0101);

    // Starvation: CPU asks every cycle, dump forced through every fifth slot
    got.delete(); got_done = 0;
    start_dump(8'h80, 9'd30);
    for (int c = 0; c < 20; c++) begin
      tick();
      i_dbg_start = 1'b0;
      i_cpu_req = 1'b1; i_cpu_we = 1'b0; i_cpu_addr = ADDR_W'($urandom);
      #2;
      if (!o_cpu_gnt) denials.push_back(c + 1);
    end
    check("t4_denials", denials.size(), 4);
    for (int k = 0; k < 4; k++) check("t4_denial_slot", (denials.size() > k) ? denials[k] : 0, 5 * (k + 1));
    i_cpu_req = 1'b0;
    drain(100);
    check("t4_done", got_done, 1);

    // Consumer stall holds the word and leaves every slot to the CPU
    got.delete(); got_done = 0;
    i_dbg_ready = 1'b0;
    start_dump(8'h20, 9'd3);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      i_dbg_start = 1'b0;
      #2;
      seen = o_dbg_valid;
    end
    check("t5_first_valid", seen, 1);
    hold = o_dbg_data;
    check("t5_first_word", hold, init_word(8'h20));
    for (int c = 0; c < 10; c++) begin
      tick();
      i_cpu_req = 1'b1; i_cpu_we = $urandom_range(0, 1) == 1;
      i_cpu_addr = ADDR_W'($urandom); i_cpu_wdata = $urandom;
      #2;
      check("t5_data_stable", o_dbg_data, hold);
      check("t5_valid_held", o_dbg_valid, 1);
      check("t5_cpu_gnt", o_cpu_gnt, 1);
    end
    tick();
    i_cpu_req = 1'b0; i_cpu_we = 1'b0; i_dbg_ready = 1'b1;
    #2;
    drain(40);
    check("t5_done", got_done, 1);

    // Reset after two of five words
    start_dump(8'h40, 9'd5);
    n_acc = 0;
    for (int c = 0; c < 20 && n_acc < 2; c++) begin
      tick();
      i_dbg_start = 1'b0;
      #2;
      if (o_dbg_valid && i_dbg_ready) n_acc++;
    end
    check("t6_two_words", n_acc, 2);
    tick();
    i_reset = 1'b1;
    #2;
    tick();
    i_reset = 1'b0;
    #2;
    check("t6_busy_clr", o_dbg_busy, 0);
    check("t6_valid_clr", o_dbg_valid, 0);
    n_done = 0;
    for (int c = 0; c < 8; c++) begin
      if (o_dbg_done) n_done++;
      tick();
      #2;
    end
    check("t6_no_done", n_done, 0);

    // Random traffic against the model
    gnt_seen = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      i_reset = ($urandom_range(0, 499) == 0);
      if (!i_cpu_req || gnt_seen) begin
        i_cpu_req   = ($urandom_range(0, 9) < 6);
        i_cpu_we    = ($urandom_range(0, 1) == 1);
        i_cpu_addr  = ADDR_W'($urandom);
        i_cpu_wdata = $urandom;
      end
      i_dbg_ready = ($urandom_range(0, 3) != 0);
      i_dbg_start = ($urandom_range(0, 15) == 0);
      i_dbg_base  = ADDR_W'($urandom);
      i_dbg_len   = ($urandom_range(0, 30) == 0) ? 9'd256 : 9'($urandom_range(0, 12));
      #2;
      gnt_seen = o_cpu_gnt;
    end

    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares the single-ported data BRAM (8-bit address, 32-bit word) between two users: the pipeline MEM stage (CPU port) and a debug dump engine.
- The dump engine streams a contiguous range of memory words to the debug/UART path over a valid/ready interface.
- The CPU has priority. A starvation counter guarantees the dump engine forward progress.
- The block sits between the MEM stage, the debug unit and the BRAM.

Parameters:
- ADDR_W, 8, BRAM address width.
- DATA_W, 32, BRAM word width.
- STARVE_LIMIT, 4, consecutive denied dump-slot cycles after which the dump engine is forced one slot.

Ports:
- clk  in  1  system clock; BRAM writes on rising edge, registers read data on falling edge.
- i_reset  in  1  synchronous, active-high reset.
- i_cpu_req  in  1  CPU access request, held until granted.
- i_cpu_we  in  1  1 = write, 0 = read.
- i_cpu_addr  in  ADDR_W  CPU address.
- i_cpu_wdata  in  DATA_W  CPU write data.
- o_cpu_gnt  out  1  combinational grant, this cycle.
- o_cpu_rdata  out  DATA_W  registered read data.
- o_cpu_rvalid  out  1  one-cycle pulse; o_cpu_rdata valid.
- i_dbg_start  in  1  start dump (single-cycle pulse).
- i_dbg_base  in  ADDR_W  first dump address, sampled on start.
- i_dbg_len  in  ADDR_W+1  word count, sampled on start (0..256).
- o_dbg_data  out  DATA_W  dump word.
- o_dbg_valid  out  1  o_dbg_data valid.
- i_dbg_ready  in  1  consumer accepts word.
- o_dbg_busy  out  1  dump in progress.
- o_dbg_done  out  1  one-cycle pulse at dump completion.
- o_mem_we  out  1  to BRAM write enable.
- o_mem_addr  out  ADDR_W  to BRAM address.
- o_mem_wdata  out  DATA_W  to BRAM data in.
- i_mem_rdata  in  DATA_W  from BRAM data out.

Behaviour:

Reset:
- Outputs after reset: o_cpu_rvalid=0, o_cpu_rdata=0, o_dbg_valid=0, o_dbg_data=0, o_dbg_busy=0, o_dbg_done=0.
- FSM=IDLE, starvation counter=0.
- Mem outputs are muxed combinationally. With no grant: o_mem_we=0, o_mem_addr=0, o_mem_wdata=0.

Slot rules (one memory access per cycle):
- A dump slot is wanted when FSM=RUN, words remain to issue, and the output buffer is free. The buffer is free when o_dbg_valid=0, or when o_dbg_valid=1 and i_dbg_ready=1 in the same cycle.
- If i_cpu_req=1 and the starvation counter is below STARVE_LIMIT: the CPU wins, o_cpu_gnt=1. If a dump slot was wanted, the counter increments.
- If the counter equals STARVE_LIMIT and a dump slot is wanted: the dump wins, o_cpu_gnt=0, counter clears.
- When a dump slot is taken without contention, the counter clears.

Read latency:
- The BRAM registers read data on the falling edge of the grant cycle.
- The arbiter captures i_mem_rdata on the next rising edge.
- CPU read granted in cycle N gives o_cpu_rvalid=1 with data in cycle N+1.
- CPU writes take effect at the end of the grant cycle. No rvalid is produced for writes.

Dump FSM:
- IDLE: on i_dbg_start, latch base address and count.
  - len=0: go to DONE.
  - Otherwise: go to RUN, o_dbg_busy=1.
- RUN: each taken dump slot reads the current address, then increments the address modulo 2^ADDR_W (base 0xFE, len 4 reads FE, FF, 00, 01) and decrements the remaining count.
  - Captured data loads o_dbg_data, o_dbg_valid=1 on the next cycle.
  - The word is held stable until i_dbg_ready=1.
  - When the count reaches 0 and the last word is accepted, go to DONE.
- DONE: o_dbg_done=1 for one cycle, o_dbg_busy=0, then IDLE.

Edge cases:
- i_dbg_start while not IDLE is ignored.
- Reset mid-dump: return to IDLE with no done pulse; the pending word is dropped.
- CPU write and dump read to the same address in consecutive slots resolve in slot order. The earlier slot's effect is visible to the later slot.
- No CPU request and no dump slot wanted: mem idle, counter unchanged.

Optional Feature:
- Macro: ARB_STALL_CNT_EN.
- With the macro: adds output o_stall_cnt (16 bits), which counts cycles with i_cpu_req=1 and o_cpu_gnt=0. It saturates at 0xFFFF and clears on reset.
- Without the macro: the port and counter are absent; arbitration is identical.

Test Plan:
- CPU write 0xDEADBEEF to 0x10, then read 0x10 -> o_cpu_gnt=1 both cycles; o_cpu_rvalid pulses the cycle after the read grant with 0xDEADBEEF.
- Dump base=0x00, len=3, i_dbg_ready=1, no CPU traffic -> three consecutive valid words = mem[0..2]; o_dbg_done pulses once; busy low afterwards.
- Dump base=0xFE, len=4 -> words mem[FE], mem[FF], mem[00], mem[01] in order.
- CPU requests every cycle during a dump, STARVE_LIMIT=4 -> dump gets exactly one slot per 5 cycles; CPU denied on those cycles only.
- i_dbg_ready held 0 for 10 cycles after the first word -> o_dbg_data is stable; no further reads are issued; CPU is always granted.
- Reset asserted mid-dump (after 2 of 5 words) -> next cycle busy=0, valid=0; no done pulse.
